mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and the MEM-stage
// data port. Data has priority unless fetch has lost STARVE_MAX decisions in a row.
module mem_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        d_req_i,
  input  logic        d_rw_i,
  input  logic        d_bw_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        mem_ce_o,
  output logic        mem_rw_o,
  output logic        mem_bw_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_if_c_o,
  output logic        stall_mem_c_o,
  output logic        busy_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_ACC  = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    lat_cnt_q;
  logic [CNT_W-1:0]    starve_cnt_q;
  logic                mem_ce_q;
  logic                mem_rw_q;
  logic                mem_bw_q;
  logic [DATA_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                if_ack_q;
  logic                d_ack_q;
  logic                busy_q;

  // A port is not eligible in the cycle its ack is showing.
  logic if_elig;
  logic d_elig;
  logic d_win;
  assign if_elig = if_req_i & ~if_ack_q;
  assign d_elig  = d_req_i & ~d_ack_q;
  assign d_win   = d_elig & (~if_elig | (starve_cnt_q != STARVE_LIM));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      mem_ce_q     <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_bw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (d_win) begin
            state_q     <= D_ACC;
            lat_cnt_q   <= '0;
            mem_ce_q    <= 1'b1;
            mem_rw_q    <= d_rw_i;
            mem_bw_q    <= d_bw_i & ~d_rw_i;
            mem_addr_q  <= d_addr_i;
            mem_wdata_q <= d_wdata_i;
            busy_q      <= 1'b1;
            if (if_elig && (starve_cnt_q != STARVE_LIM)) begin
              starve_cnt_q <= starve_cnt_q + CNT_W'(1);
            end
          end else if (if_elig) begin
            state_q      <= IF_ACC;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            mem_ce_q     <= 1'b1;
            mem_rw_q     <= 1'b1;
            mem_bw_q     <= 1'b0;
            mem_addr_q   <= if_addr_i;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b1;
          end
        end
        IF_ACC, D_ACC: begin
          if (lat_cnt_q == LAST_CNT) begin
            // Last access cycle: release memory, capture data, pulse ack.
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            mem_ce_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_bw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            if (state_q == IF_ACC) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_rdata_i;
            end else begin
              d_ack_q <= 1'b1;
              if (mem_rw_q) begin
                d_rdata_q <= mem_rdata_i;
              end
            end
          end else begin
            lat_cnt_q <= lat_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_ack_o     = d_ack_q;
  assign mem_ce_o    = mem_ce_q;
  assign mem_rw_o    = mem_rw_q;
  assign mem_bw_o    = mem_bw_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;

  assign stall_if_c_o  = if_req_i & ~if_ack_q;
  assign stall_mem_c_o = d_req_i & ~d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: u_dut uses MEM_LAT=2/STARVE_MAX=3, u_dut1 uses MEM_LAT=1.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;

  logic        if_req, d_req, d_rw, d_bw;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_ce, mem_rw, mem_bw, stall_if, stall_mem, busy;

  logic        if_req1, d_req1, d_rw1, d_bw1;
  logic [31:0] if_addr1, d_addr1, d_wdata1, mem_rdata1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic        if_ack1, d_ack1, mem_ce1, mem_rw1, mem_bw1, stall_if1, stall_mem1, busy1;

  int n_total;
  int n_pass;

  mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(3)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .d_req_i(d_req), .d_rw_i(d_rw), .d_bw_i(d_bw), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_ack_o(d_ack),
    .mem_ce_o(mem_ce), .mem_rw_o(mem_rw), .mem_bw_o(mem_bw), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .stall_if_c_o(stall_if), .stall_mem_c_o(stall_mem), .busy_o(busy)
  );

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req1), .if_addr_i(if_addr1), .if_rdata_o(if_rdata1), .if_ack_o(if_ack1),
    .d_req_i(d_req1), .d_rw_i(d_rw1), .d_bw_i(d_bw1), .d_addr_i(d_addr1), .d_wdata_i(d_wdata1),
    .d_rdata_o(d_rdata1), .d_ack_o(d_ack1),
    .mem_ce_o(mem_ce1), .mem_rw_o(mem_rw1), .mem_bw_o(mem_bw1), .mem_addr_o(mem_addr1),
    .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata1),
    .stall_if_c_o(stall_if1), .stall_mem_c_o(stall_mem1), .busy_o(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0;
    if_req = 0; d_req = 0; d_rw = 0; d_bw = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    if_req1 = 0; d_req1 = 0; d_rw1 = 0; d_bw1 = 0;
    if_addr1 = '0; d_addr1 = '0; d_wdata1 = '0; mem_rdata1 = '0;

    // Reset state
    tick(); tick();
    chk("rst_mem_ce", 32'(mem_ce), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    // Fetch only
    if_req = 1; if_addr = 32'h100; mem_rdata = 32'h00A00093;
    #1 chk("f_stall_if_c0", 32'(stall_if), 32'd1);
    tick();
    chk("f_ce_c1", 32'(mem_ce), 32'd1);
    chk("f_addr_c1", mem_addr, 32'h100);
    chk("f_rw_c1", 32'(mem_rw), 32'd1);
    chk("f_busy_c1", 32'(busy), 32'd1);
    tick();
    chk("f_ce_c2", 32'(mem_ce), 32'd1);
    chk("f_ack_c2", 32'(if_ack), 32'd0);
    tick();
    chk("f_ack_c3", 32'(if_ack), 32'd1);
    chk("f_rdata_c3", if_rdata, 32'h00A00093);
    chk("f_ce_c3", 32'(mem_ce), 32'd0);
    chk("f_addr_c3", mem_addr, 32'd0);
    chk("f_stall_if_c3", 32'(stall_if), 32'd0);
    if_req = 0;
    tick();
    chk("f_ack_c4", 32'(if_ack), 32'd0);

    // Simultaneous: store first, fetch granted in the d_ack cycle
    if_req = 1; if_addr = 32'h104; mem_rdata = 32'h11111111;
    d_req = 1; d_rw = 0; d_bw = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    tick();
    chk("s_addr_c1", mem_addr, 32'h200);
    chk("s_rw_c1", 32'(mem_rw), 32'd0);
    chk("s_bw_c1", 32'(mem_bw), 32'd1);
    chk("s_wdata_c1", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("s_ce_c2", 32'(mem_ce), 32'd1);
    tick();
    chk("s_dack_c3", 32'(d_ack), 32'd1);
    chk("s_store_rdata_c3", d_rdata, 32'd0);
    d_req = 0;
    tick();
    chk("s_if_addr_c4", mem_addr, 32'h104);
    chk("s_if_rw_c4", 32'(mem_rw), 32'd1);
    chk("s_if_wdata_c4", mem_wdata, 32'd0);
    chk("s_dack_c4", 32'(d_ack), 32'd0);
    tick();
    chk("s_ifack_c5", 32'(if_ack), 32'd0);
    tick();
    chk("s_ifack_c6", 32'(if_ack), 32'd1);
    chk("s_if_rdata_c6", if_rdata, 32'h11111111);
    if_req = 0;
    tick();

    // Load with bw asserted: bw must be masked on reads
    d_req = 1; d_rw = 1; d_bw = 1; d_addr = 32'h40; mem_rdata = 32'h12345678;
    #1 chk("l_stall_c0", 32'(stall_mem), 32'd1);
    tick();
    chk("l_addr_c1", mem_addr, 32'h40);
    chk("l_rw_bw_c1", {30'd0, mem_rw, mem_bw}, 32'd2);
    chk("l_stall_c1", 32'(stall_mem), 32'd1);
    tick();
    chk("l_stall_c2", 32'(stall_mem), 32'd1);
    tick();
    chk("l_dack_c3", 32'(d_ack), 32'd1);
    chk("l_rdata_c3", d_rdata, 32'h12345678);
    chk("l_stall_c3", 32'(stall_mem), 32'd0);
    d_req = 0;
    tick();
    chk("l_stall_c4", 32'(stall_mem), 32'd0);

    // Store keeps previous load data
    d_req = 1; d_rw = 0; d_bw = 0; d_addr = 32'h44; d_wdata = 32'h0; mem_rdata = 32'hCAFEF00D;
    tick(); tick(); tick();
    chk("st_dack", 32'(d_ack), 32'd1);
    chk("st_rdata_hold", d_rdata, 32'h12345678);
    d_req = 0;
    tick();

    // Starvation: fetch loses three contested decisions, then is forced in
    if_addr = 32'h400;
    for (int k = 0; k < 3; k++) begin
      if_req = 1; d_req = 1; d_rw = 0; d_bw = 0; d_addr = 32'h300 + 32'(k * 4);
      tick();
      chk($sformatf("sv_dwin%0d", k), mem_addr, 32'h300 + 32'(k * 4));
      if_req = 0;
      tick(); tick();
      chk($sformatf("sv_dack%0d", k), 32'(d_ack), 32'd1);
      d_req = 0;
      tick();
    end
    if_req = 1; d_req = 1; d_addr = 32'h310;
    tick();
    chk("sv_forced_if_addr", mem_addr, 32'h400);
    chk("sv_forced_if_rw", 32'(mem_rw), 32'd1);
    tick(); tick();
    chk("sv_forced_ifack", 32'(if_ack), 32'd1);
    if_req = 0;
    tick();
    chk("sv_d_after_if", mem_addr, 32'h310);
    tick(); tick();
    d_req = 0;
    tick();
    if_req = 1; d_req = 1; d_addr = 32'h320;
    tick();
    chk("sv_cnt_cleared_dwin", mem_addr, 32'h320);
    if_req = 0;
    tick(); tick();
    d_req = 0;
    tick();

    // Reset in the second D_ACC cycle drops the access
    d_req = 1; d_rw = 1; d_addr = 32'h80; mem_rdata = 32'h55AA55AA;
    tick();
    chk("r_ce_c1", 32'(mem_ce), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("r_ce_c3", 32'(mem_ce), 32'd0);
    chk("r_busy_c3", 32'(busy), 32'd0);
    chk("r_dack_c3", 32'(d_ack), 32'd0);
    chk("r_rdata_cleared", d_rdata, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("r_regrant_c4", mem_addr, 32'h80);
    chk("r_dack_c4", 32'(d_ack), 32'd0);
    tick();
    chk("r_dack_c5", 32'(d_ack), 32'd0);
    tick();
    chk("r_dack_c6", 32'(d_ack), 32'd1);
    chk("r_rdata_c6", d_rdata, 32'h55AA55AA);
    d_req = 0;
    tick();

    // MEM_LAT=1 back-to-back fetches: one ack every 3 cycles
    if_req1 = 1; if_addr1 = 32'h500; mem_rdata1 = 32'h00000077;
    chk("b_busy_dec0", 32'(busy1), 32'd0);
    for (int p = 0; p < 3; p++) begin
      tick();
      chk($sformatf("b_ce%0d", p), 32'(mem_ce1), 32'd1);
      chk($sformatf("b_busy_acc%0d", p), 32'(busy1), 32'd1);
      tick();
      chk($sformatf("b_ack%0d", p), 32'(if_ack1), 32'd1);
      chk($sformatf("b_ce_off%0d", p), 32'(mem_ce1), 32'd0);
      tick();
      chk($sformatf("b_noack%0d", p), 32'(if_ack1), 32'd0);
      chk($sformatf("b_busy_dec%0d", p), 32'(busy1), 32'd0);
    end
    chk("b_rdata", if_rdata1, 32'h00000077);
    if_req1 = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
